seq_detect_1011_sched: RTL and testbench
========================================

// Module: seq_detect_1011_sched
// PURPOSE
//  Shares one 1011 sequence-detector FSM among NUM_REQ requesters.
//  Requesters submit WORD_W-bit words over valid/ready; a round-robin arbiter picks one word.
//  The controller clears the detector, serialises the word MSB-first onto its input bit,
//  counts seq_seen hits, and returns {requester id, hit count} on a valid/ready result port.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  WORD_W   8  bits per submitted word (>=4)
//  ID_W     2  width of done_id; must equal $clog2(NUM_REQ)
//  CNT_W    4  width of done_count; must equal $clog2(WORD_W+1)
// PORTS
//  clk         in   1               rising-edge clock
//  reset       in   1               synchronous, active-high reset
//  req_valid   in   NUM_REQ         per-requester word valid
//  req_data    in   NUM_REQ*WORD_W  word for requester i in bits [i*WORD_W +: WORD_W]
//  req_ready   out  NUM_REQ         one-hot accept; a transfer occurs when req_valid[i] & req_ready[i]
//  det_reset   out  1               reset to the detector (synchronous, active-high)
//  det_inp_bit out  1               serial bit to the detector
//  det_seen    in   1               detector seq_seen (comb. of its registered state)
//  done_valid  out  1               result valid
//  done_id     out  ID_W            index of the requester the result belongs to
//  done_count  out  CNT_W           number of 1011 detections in the word
//  done_ready  in   1               result consumer ready
//  busy        out  1               high in every state except IDLE
// BEHAVIOUR
//  FSM states: IDLE -> CLR -> SHIFT -> DRAIN -> DONE -> IDLE.
//  - IDLE:
//    - Grant goes to the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - req_ready[grant] = 1 (combinational from req_valid); all other ready bits are 0.
//    - On transfer: capture word, set id = grant, rr_ptr <= (grant+1) mod NUM_REQ, go to CLR.
//    - If no req_valid: stay in IDLE; rr_ptr unchanged.
//  - CLR: det_reset = 1 for exactly 1 cycle; count <= 0; bit index <= 0; go to SHIFT.
//  - SHIFT (WORD_W cycles):
//    - In shift cycle k, det_inp_bit = word[WORD_W-1-k].
//    - det_seen is sampled in cycles k = 1..WORD_W-1; each sampled 1 adds 1 to count.
//    - After k = WORD_W-1, go to DRAIN.
//  - DRAIN: 1 cycle; det_seen is sampled once more (hit on the last bit); go to DONE.
//  - DONE:
//    - done_valid = 1; done_id and done_count held stable.
//    - On done_valid & done_ready, go to IDLE.
//    - No new request is accepted before the cycle after the result handshake.
//  Outputs and timing:
//  - det_inp_bit = 0 outside SHIFT.
//  - det_reset = reset | (state == CLR).
//  - Latency: done_valid rises exactly WORD_W+2 clock edges after the accepting edge.
//    Minimum spacing between accepts is WORD_W+4 cycles.
//  - req_ready is 0 in every state except IDLE.
//    Requesters hold req_valid and req_data until accepted.
//  - count cannot overflow: at most WORD_W/3 hits per word, and CNT_W covers WORD_W.
//  Reset:
//  - Reset wins over all other activity; this includes reset mid-SHIFT or mid-DONE.
//  - On reset: state = IDLE, rr_ptr = 0, count = 0, captured word/id = 0, and the in-flight result is discarded.
//  - Output values under reset: req_ready = 0, det_reset = 1, det_inp_bit = 0,
//    done_valid = 0, done_id = 0, done_count = 0, busy = 0.
// TESTING
//  All scenarios use NUM_REQ=4, WORD_W=8, and a detector that matches overlapping 1011 instances.
//  1. req_valid=0001, data0=8'hBB, done_ready=1 -> req_ready=0001; det bits 1,0,1,1,1,0,1,1;
//     done_id=0, done_count=2, done_valid 10 edges after accept.
//  2. Single words on requester 2: 8'hB0 -> count 1; 8'hFF -> 0; 8'h00 -> 0;
//     8'h2D (00101101) -> 1.
//  3. req_valid=1111 held, all data 8'hB0, done_ready=1 -> accept order 0,1,2,3,0;
//     the grant never repeats while others wait.
//  4. done_ready=0 for 5 cycles in DONE -> done_valid/id/count stable; req_ready=0;
//     accept occurs only after the handshake.
//  5. reset asserted in the 4th SHIFT cycle -> next cycle: IDLE, busy=0, done_valid=0, rr_ptr=0;
//     a fresh word gives the correct count.
//  6. Back-to-back words 8'hB0 then 8'h0B on requester 1 -> counts 1 and 1.
//     det_reset pulses before each word; no carry-over between words.

Source files
------------

// File: rtl/seq_detect_1011_sched.sv
// Shares one 1011 sequence detector among NUM_REQ round-robin requesters:
// each granted word is serialised MSB-first into the detector and its hit count is returned.
module seq_detect_1011_sched #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      det_reset,
  output logic                      det_inp_bit,
  input  logic                      det_seen,
  output logic                      done_valid,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          done_count,
  input  logic                      done_ready,
  output logic                      busy
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t            state, next_state;
  logic [ID_W-1:0]   rr_ptr;
  logic [WORD_W-1:0] word;
  logic [ID_W-1:0]   id;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  bit_idx;

  logic              grant_found;
  logic [ID_W-1:0]   grant;
  logic [31:0]       cand;
  logic              transfer;

  // Rotating priority scan starting at rr_ptr
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cand = (32'(rr_ptr) + j) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant       = ID_W'(cand);
      end
    end
  end

  // All outputs are forced to their reset values while reset is high
  always_comb begin
    next_state  = state;
    req_ready   = '0;
    transfer    = 1'b0;
    det_reset   = reset;
    det_inp_bit = 1'b0;
    done_valid  = 1'b0;
    done_id     = '0;
    done_count  = '0;
    busy        = 1'b0;
    if (!reset) begin
      busy       = (state != IDLE);
      done_id    = id;
      done_count = count;
      case (state)
        IDLE: begin
          if (grant_found) begin
            req_ready[grant] = 1'b1;
            transfer         = 1'b1;
            next_state       = CLR;
          end
        end
        CLR: begin
          det_reset  = 1'b1;
          next_state = SHIFT;
        end
        SHIFT: begin
          det_inp_bit = word[IDX_W'(WORD_W-1) - bit_idx];
          if (bit_idx == IDX_W'(WORD_W-1)) next_state = DRAIN;
        end
        DRAIN: next_state = DONE;
        DONE: begin
          done_valid = 1'b1;
          if (done_ready) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      word    <= '0;
      id      <= '0;
      count   <= '0;
      bit_idx <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (transfer) begin
            word   <= req_data[grant*WORD_W +: WORD_W];
            id     <= grant;
            rr_ptr <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);
          end
        end
        CLR: begin
          count   <= '0;
          bit_idx <= '0;
        end
        SHIFT: begin
          // det_seen lags the bit stream by one cycle, so shift cycle 0 never carries a hit
          if ((bit_idx != '0) && det_seen) count <= count + CNT_W'(1);
          bit_idx <= bit_idx + IDX_W'(1);
        end
        DRAIN: begin
          if (det_seen) count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_1011_sched.sv
// Self-checking bench: directed scenarios plus randomized words and request masks,
// checked against a substring-count and round-robin reference model.
module tb_seq_detect_1011_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           det_reset;
  logic           det_inp_bit;
  logic           det_seen;
  logic           done_valid;
  logic [IW-1:0]  done_id;
  logic [CW-1:0]  done_count;
  logic           done_ready;
  logic           busy;

  always #5 clk = ~clk;

  seq_detect_1011_sched #(.NUM_REQ(N), .WORD_W(W), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .det_reset(det_reset), .det_inp_bit(det_inp_bit),
    .det_seen(det_seen), .done_valid(done_valid), .done_id(done_id),
    .done_count(done_count), .done_ready(done_ready), .busy(busy)
  );

  // Overlapping 1011 detector: flags when the last four registered bits read 1011
  logic [3:0] hist;
  always @(posedge clk) begin
    if (det_reset) hist <= 4'b0000;
    else           hist <= {hist[2:0], det_inp_bit};
  end
  assign det_seen = (hist == 4'b1011);

  int tests = 0;
  int fails = 0;
  int rr_model = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_grant(input logic [N-1:0] m, input int ptr);
    for (int j = 0; j < N; j++) begin
      if (m[(ptr + j) % N]) return (ptr + j) % N;
    end
    return -1;
  endfunction

  // Count overlapping occurrences of 1011 in the word read MSB-first
  function automatic int ref_count(input logic [W-1:0] w);
    int c = 0;
    logic [W-1:0] t;
    for (int s = 0; s <= W - 4; s++) begin
      t = w >> s;
      if (t[3:0] == 4'b1011) c++;
    end
    return c;
  endfunction

  task automatic transact(input string tag, input int stall, input bit keep, output int gnt);
    logic [W-1:0] word;
    logic [W-1:0] bits;
    bit           bad;
    int           exp_cnt;
    #1;
    gnt = ref_grant(req_valid, rr_model);
    if (gnt < 0) begin
      check({tag, ":nogrant"}, 32'd0, 32'd1);
      return;
    end
    word    = req_data[gnt*W +: W];
    exp_cnt = ref_count(word);
    check({tag, ":ready"}, 32'(req_ready), 32'(N'(1) << gnt));
    check({tag, ":idle_busy"}, 32'(busy), 32'd0);
    done_ready = (stall == 0);
    @(posedge clk); #1;
    rr_model = (gnt + 1) % N;
    if (!keep) req_valid[gnt] = 1'b0;
    check({tag, ":clr"}, {29'd0, req_ready == '0, busy, det_reset}, 32'b111);
    bad  = 1'b0;
    bits = '0;
    for (int k = 0; k < W; k++) begin
      @(posedge clk); #1;
      bits[W-1-k] = det_inp_bit;
      if (det_reset !== 1'b0 || done_valid !== 1'b0 || req_ready !== '0) bad = 1'b1;
    end
    check({tag, ":bits"}, 32'(bits), 32'(word));
    check({tag, ":shift_ctl"}, 32'(bad), 32'd0);
    @(posedge clk); #1;
    check({tag, ":drain"}, {30'd0, done_valid, det_inp_bit}, 32'd0);
    @(posedge clk); #1;
    check({tag, ":valid"}, 32'(done_valid), 32'd1);
    check({tag, ":id"}, 32'(done_id), 32'(gnt));
    check({tag, ":count"}, 32'(done_count), 32'(exp_cnt));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, ":hold"}, {22'd0, done_valid, done_id, done_count, req_ready},
            {22'd0, 1'b1, IW'(gnt), CW'(exp_cnt), N'(0)});
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ":after_hs"}, {30'd0, done_valid, busy}, 32'd0);
  endtask

  initial begin
    int g;
    int order [5];
    reset      = 1'b1;
    req_valid  = 4'b1111;
    req_data   = $urandom;
    done_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_det", {30'd0, det_reset, det_inp_bit}, 32'b10);
    check("rst_done", {23'd0, done_valid, done_id, done_count, busy}, 32'd0);
    reset     = 1'b0;
    req_valid = '0;

    // Word 0xBB on requester 0
    req_valid = 4'b0001;
    req_data[0*W +: W] = 8'hBB;
    transact("s1", 0, 0, g);

    // Single words on requester 2
    req_valid = 4'b0100; req_data[2*W +: W] = 8'hB0; transact("s2_b0", 0, 0, g);
    req_valid = 4'b0100; req_data[2*W +: W] = 8'hFF; transact("s2_ff", 0, 0, g);
    req_valid = 4'b0100; req_data[2*W +: W] = 8'h00; transact("s2_00", 0, 0, g);
    req_valid = 4'b0100; req_data[2*W +: W] = 8'h2D; transact("s2_2d", 0, 0, g);

    // All requesters held valid: grants rotate
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; rr_model = 0;
    req_valid = 4'b1111;
    req_data  = {4{8'hB0}};
    for (int i = 0; i < 5; i++) begin
      transact("s3", 0, 1, g);
      order[i] = g;
    end
    check("s3_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]}, 32'h00010203);
    check("s3_wrap", 32'(order[4]), 32'd0);

    // Result stalled with another requester waiting
    req_valid = 4'b0101;
    req_data  = $urandom;
    transact("s4", 5, 0, g);
    transact("s4_next", 0, 0, g);

    // Reset in the 4th shift cycle
    req_valid = 4'b0100;
    req_data[2*W +: W] = 8'hB0;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) begin @(posedge clk); #1; end
    reset     = 1'b1;
    req_valid = 4'b1111;
    @(posedge clk); #1;
    check("s5_rst", {27'd0, busy, done_valid, det_reset, det_inp_bit, req_ready == '0}, 32'b00101);
    reset    = 1'b0;
    rr_model = 0;
    req_data = {8'h11, 8'h22, 8'h33, 8'hBB};
    transact("s5_fresh", 0, 0, g);
    check("s5_grant0", 32'(g), 32'd0);

    // Back-to-back on requester 1
    req_valid = 4'b0010; req_data[1*W +: W] = 8'hB0; transact("s6_b0", 0, 0, g);
    req_valid = 4'b0010; req_data[1*W +: W] = 8'h0B; transact("s6_0b", 0, 0, g);

    // Randomized masks, words, stalls
    for (int i = 0; i < 24; i++) begin
      req_valid = N'($urandom_range(1, 15));
      req_data  = $urandom;
      transact("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)), g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
